// File: rtl/shift_bus_capture.sv
// Serializes each data_in lane through a 74LS165-style shift register and rebuilds the word in SIPO receivers.
// Optional SHIFT_CAPTURE_HOLD_EN: data_out is a separate register updated only when a transfer completes.
module shift_bus_capture #(
    parameter int  LANE_W = 8,
    parameter int  LANES  = 2,
    localparam int DATA_W = LANE_W * LANES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              shld,
    output logic              serclk,
    output logic [4:0]        count,
    output logic              done,
    output logic [LANES-1:0]  ser_out,
    output logic [DATA_W-1:0] data_out
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'(LANE_W);

    state_t                       state_q,  state_d;
    logic                         serclk_q, serclk_d;
    logic [4:0]                   count_q,  count_d;
    logic                         done_q,   done_d;
    logic [LANES-1:0][LANE_W-1:0] tx_q, tx_d;
    logic [LANES-1:0][LANE_W-1:0] rx_q, rx_d;

    // Every bit takes a low and a high serclk cycle; all lanes move together on the rising half.
    always_comb begin
        state_d  = state_q;
        serclk_d = serclk_q;
        count_d  = count_q;
        done_d   = done_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        case (state_q)
            LOAD: begin
                tx_d     = data_in;
                state_d  = SHIFT;
                serclk_d = 1'b0;
                count_d  = '0;
                done_d   = 1'b0;
            end
            SHIFT: begin
                if (!serclk_q) begin
                    serclk_d = 1'b1;
                    count_d  = count_q + 5'd1;
                    for (int k = 0; k < LANES; k++) begin
                        rx_d[k] = {rx_q[k][LANE_W-2:0], tx_q[k][LANE_W-1]};
                        tx_d[k] = {tx_q[k][LANE_W-2:0], 1'b0};
                    end
                end else begin
                    serclk_d = 1'b0;
                    if (count_q == LAST_BIT) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = LOAD;
                    done_d  = 1'b0;
                    count_d = '0;
                end
            end
            default: begin
                state_d  = LOAD;
                serclk_d = 1'b0;
                count_d  = '0;
                done_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOAD;
            serclk_q <= 1'b0;
            count_q  <= '0;
            done_q   <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            state_q  <= state_d;
            serclk_q <= serclk_d;
            count_q  <= count_d;
            done_q   <= done_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    // The load strobe must stay inactive while reset holds the controller in LOAD.
    assign shld   = reset | (state_q != LOAD);
    assign serclk = serclk_q;
    assign count  = count_q;
    assign done   = done_q;

    always_comb begin
        ser_out = '0;
        for (int k = 0; k < LANES; k++) begin
            ser_out[k] = tx_q[k][LANE_W-1];
        end
    end

`ifdef SHIFT_CAPTURE_HOLD_EN
    logic [DATA_W-1:0] hold_q, hold_d;

    // Latch the receivers on the edge that enters DONE, when the last bit has landed.
    always_comb begin
        hold_d = hold_q;
        if (state_q == SHIFT && serclk_q && count_q == LAST_BIT) begin
            hold_d = rx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign data_out = hold_q;
`else
    assign data_out = rx_q;
`endif

endmodule

// File: tb/tb_shift_bus_capture.sv
// Self-checking bench for shift_bus_capture: vector table, corner sequences and random transfers vs. a cycle model.
module tb_shift_bus_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic        shld;
    logic        serclk;
    logic [4:0]  count;
    logic        done;
    logic [1:0]  ser_out;
    logic [15:0] data_out;

    shift_bus_capture dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .shld     (shld),
        .serclk   (serclk),
        .count    (count),
        .done     (done),
        .ser_out  (ser_out),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        shld;
        logic        serclk;
        logic [4:0]  count;
        logic        done;
        logic [1:0]  serOut;
        logic [15:0] dataOut;
    } expT;

    typedef struct {
        logic [15:0] dataIn;
        logic [15:0] expOut;
        logic [7:0]  lane1Seq;
        logic [7:0]  lane0Seq;
        bit          noise;
    } vecT;

    int          total = 0;
    int          bad = 0;
    int          cyc = -1;
    logic [15:0] word = '0;
    logic [15:0] prevCap = '0;
    vecT         vecs[6];

    // Expected outputs for cycle c of a transfer of word w, where prev is the previously captured word.
    // c < 0 stands for the cycle right after a reset edge.
    function automatic expT model(input int c, input logic [15:0] w, input logic [15:0] prev);
        expT         e;
        int          n;
        logic [7:0]  slice;
        logic [7:0]  ps;
        logic [15:0] pair;
        e = '0;
        e.shld = 1'b1;
        if (c < 0) return e;
        if (c == 0) begin
            e.shld    = 1'b0;
            e.dataOut = prev;
            return e;
        end
        if (c >= 17) begin
            e.done    = 1'b1;
            e.count   = 5'd8;
            e.dataOut = w;
            return e;
        end
        n        = c / 2;
        e.serclk = (c % 2 == 0);
        e.count  = 5'(n);
        for (int k = 0; k < 2; k++) begin
            slice = w[k*8 +: 8];
            ps    = prev[k*8 +: 8];
            e.serOut[k] = (n < 8) ? slice[7-n] : 1'b0;
            pair  = {ps, slice};
            e.dataOut[k*8 +: 8] = 8'(pair >> (8 - n));
        end
`ifdef SHIFT_CAPTURE_HOLD_EN
        e.dataOut = prev;
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        expT e;
        expT a;
        e = model(cyc, word, prevCap);
        a.shld    = shld;
        a.serclk  = serclk;
        a.count   = count;
        a.done    = done;
        a.serOut  = ser_out;
        a.dataOut = data_out;
        total++;
        if (a !== e) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got shld=%b serclk=%b count=%0d done=%b ser_out=%b data_out=%h want shld=%b serclk=%b count=%0d done=%b ser_out=%b data_out=%h",
                     tag, cyc, a.shld, a.serclk, a.count, a.done, a.serOut, a.dataOut,
                     e.shld, e.serclk, e.count, e.done, e.serOut, e.dataOut);
        end
    endtask

    task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Drives one transfer starting in its LOAD cycle, checking every cycle up to stopAt.
    task automatic applyStimulus(input logic [15:0] w, input bit noise, input int stopAt, input string tag,
                                 output logic [7:0] seq1, output logic [7:0] seq0, output int highs);
        word    = w;
        data_in = w;
        start   = 1'b0;
        seq1    = '0;
        seq0    = '0;
        highs   = 0;
        for (int c = 0; c <= stopAt; c++) begin
            cyc = c;
            checkOutput(tag);
            if (serclk) highs++;
            if (c >= 1 && c <= 16 && (c % 2) == 1) begin
                seq1 = {seq1[6:0], ser_out[1]};
                seq0 = {seq0[6:0], ser_out[0]};
            end
            if (c < stopAt) begin
                if (noise) begin
                    if (c == 0) begin
                        start = 1'b1;
                    end else begin
                        data_in = (c % 2 == 1) ? 16'hFFFF : 16'($urandom);
                        start   = 1'($urandom_range(0, 1));
                    end
                end
                tick();
            end
        end
        start = 1'b0;
        if (stopAt >= 17) prevCap = w;
    endtask

    task automatic doReset(input string tag);
        reset = 1'b1;
        tick();
        cyc     = -1;
        prevCap = '0;
        word    = '0;
        checkOutput(tag);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [7:0]  s1;
        logic [7:0]  s0;
        int          highs;
        logic [15:0] w;

        vecs[0] = '{16'hC003, 16'hC003, 8'hC0, 8'h03, 1'b0};
        vecs[1] = '{16'hA55A, 16'hA55A, 8'hA5, 8'h5A, 1'b1};
        vecs[2] = '{16'h1234, 16'h1234, 8'h12, 8'h34, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 8'h00, 8'h00, 1'b1};
        vecs[5] = '{16'h8001, 16'h8001, 8'h80, 8'h01, 1'b0};

        tick();
        doReset("reset_state");

        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                data_in = vecs[i].dataIn;
                start   = 1'b1;
                tick();
            end
            applyStimulus(vecs[i].dataIn, vecs[i].noise, 17, $sformatf("vec%0d", i), s1, s0, highs);
            checkValue($sformatf("vec%0d_data_out", i), data_out, vecs[i].expOut);
            checkValue($sformatf("vec%0d_lane1_bits", i), {8'h00, s1}, {8'h00, vecs[i].lane1Seq});
            checkValue($sformatf("vec%0d_lane0_bits", i), {8'h00, s0}, {8'h00, vecs[i].lane0Seq});
            checkValue($sformatf("vec%0d_serclk_pulses", i), 16'(highs), 16'd8);
        end

        // DONE must hold without a start pulse regardless of data_in.
        for (int i = 0; i < 4; i++) begin
            data_in = 16'($urandom);
            tick();
            cyc = 17;
            checkOutput("done_hold");
        end

        // Reset in the middle of a transfer, then a clean transfer afterwards.
        data_in = 16'h3C96;
        start   = 1'b1;
        tick();
        applyStimulus(16'h3C96, 1'b0, 9, "mid_reset_pre", s1, s0, highs);
        doReset("mid_reset_state");
        applyStimulus(16'h5AC3, 1'b0, 17, "mid_reset_post", s1, s0, highs);
        checkValue("mid_reset_post_data_out", data_out, 16'h5AC3);

        for (int i = 0; i < 12; i++) begin
            w       = 16'($urandom);
            data_in = w;
            start   = 1'b1;
            tick();
            applyStimulus(w, 1'($urandom_range(0, 1)), 17, $sformatf("rand%0d", i), s1, s0, highs);
            checkValue($sformatf("rand%0d_data_out", i), data_out, w);
            checkValue($sformatf("rand%0d_lanes", i), {s1, s0}, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
